pic_host_ctrl: RTL and testbench
================================

Name: pic_host_ctrl

Overview:
- CPU-side bus master for the 8259A PIC: the other end of the PIC's host interface.
- After reset it runs the ICW initialization write sequence, then serves single OCW write requests from local logic.
- Answers INT with the two-pulse INTA acknowledge cycle and returns the captured vector byte on a one-cycle valid strobe.
- Sits between the PIC instance and the system/CPU model; the top level tri-states the shared D bus using d_oe.

Parameters:
- ICW1, 8'h13: init word 1 (A0=0). Bit1 = SNGL, bit0 = IC4.
- ICW2, 8'hA8: vector base (A0=1).
- ICW3, 8'h00: cascade word. Written only when ICW1[1]==0.
- ICW4, 8'h01: mode word. Written only when ICW1[0]==1.
- OCW1, 8'h00: initial mask (A0=1). Always written last.
- SETUP_CYC, 2: cycles CS/A0/D are valid before the WR/INTA falling edge (1..255).
- PULSE_CYC, 3: WR/INTA low width in cycles (1..255).
- HOLD_CYC, 2: cycles after the WR rising edge, and gap between INTA pulses (1..255).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin the init sequence (level, sampled in IDLE).
- init_done, out, 1: high once OCW1 completes; stays high until reset.
- busy, out, 1: high in any state except IDLE/READY.
- ocw_req, in, 1: request a single register write (honoured only in READY).
- ocw_a0, in, 1: A0 for the requested write.
- ocw_data, in, 8: data for the requested write.
- ocw_ack, out, 1: one-cycle pulse at the end of the requested write.
- cs_n, out, 1: PIC chip select.
- wr_n, out, 1: PIC write strobe.
- rd_n, out, 1: PIC read strobe; held 1 (no status reads in this block).
- a0, out, 1: PIC address line.
- d_out, out, 8: data driven onto D.
- d_oe, out, 1: D output enable.
- d_in, in, 8: D bus sampled during INTA.
- intr, in, 1: PIC INT, asynchronous to clk.
- inta_n, out, 1: interrupt acknowledge to the PIC.
- vec_valid, out, 1: one-cycle strobe when vector is captured.
- vec_data, out, 8: captured vector; holds value until the next capture.

Behaviour:
- Reset values: cs_n=1, wr_n=1, rd_n=1, inta_n=1, a0=0, d_out=0, d_oe=0, init_done=0, busy=0, ocw_ack=0, vec_valid=0, vec_data=0.
- Reset asserted mid-cycle aborts immediately; the bus returns to the reset values asynchronously.
- intr passes through a 2-flop synchronizer, giving 2 cycles of latency.
- Bus write timing, all states registered:
  - WSETUP: SETUP_CYC cycles with cs_n=0, d_oe=1, a0/d_out valid, wr_n=1.
  - WPULSE: PULSE_CYC cycles with wr_n=0.
  - WHOLD: HOLD_CYC cycles with wr_n=1, cs_n/a0/d still driven.
  - After WHOLD, cs_n=1 and d_oe=0.
  - Total write = SETUP+PULSE+HOLD cycles.
- FSM states: IDLE, WSETUP, WPULSE, WHOLD, READY, ACK1, AGAP, ACK2, VEC, RECOVER.
- IDLE: wait for start=1, then issue the init list.
- Init list is built from parameters: ICW1(a0=0), ICW2(a0=1), [ICW3(a0=1)], [ICW4(a0=1)], OCW1(a0=1). A step index selects the next word.
- After the OCW1 write: init_done=1, go to READY.
- intr and ocw_req are ignored until init_done.
- READY: synced intr=1 takes priority over ocw_req when both arrive in the same cycle.
- ocw_req path: latch ocw_a0/ocw_data, run one write, pulse ocw_ack in the last WHOLD cycle, return to READY. The requester holds ocw_req until ack.
- ACK1: inta_n=0 for PULSE_CYC cycles. cs_n, wr_n and d_oe stay inactive.
- AGAP: inta_n=1 for HOLD_CYC cycles.
- ACK2: inta_n=0 for PULSE_CYC cycles; vec_data<=d_in on the final ACK2 cycle.
- VEC: inta_n=1, vec_valid=1 for one cycle.
- RECOVER: HOLD_CYC cycles, then READY; the synchronized intr is re-evaluated there.
- If intr drops during ACK1/AGAP, the sequence still completes; the PIC supplies the IR7 vector.
- inta_n and wr_n are never low together; d_oe=0 whenever inta_n=0.
- Counter: a single 8-bit down-counter reloaded on each state entry.

Decomposition:
- Package pic_host_pkg holds:
  - the state enum;
  - the A0 constants A0_ICW1=0 and A0_OTHER=1;
  - ICW1 bit positions IC4=0 and SNGL=1.
- Sub-module pic_bus_timer: loadable 8-bit down-counter with a zero flag, shared by the write and INTA phases.

Test Plan:
- Defaults, start=1 → four writes (a0,d) = (0,13),(1,A8),(1,01),(1,00), each 7 cycles with wr_n low 3 cycles; init_done rises after the 28th write cycle.
- ICW1=8'h10 → only ICW1, ICW2, ICW3 (8'h00), OCW1 are written, and ICW4 is skipped.
- After init, ocw_req with a0=1, data=8'hFE → one 7-cycle write with d_out=FE, ocw_ack on cycle 7, busy low afterward.
- PIC model raises INT with vector 8'hA8 → inta_n low 3, high 2, low 3; vec_valid pulses once with vec_data=A8; d_oe=0 throughout.
- intr and ocw_req rise in the same cycle → the INTA sequence runs first, then the write; ocw_ack arrives after vec_valid.
- rst_n low during WPULSE of ICW2 → cs_n=1, wr_n=1, d_oe=0 immediately; the next start restarts from ICW1.

Source files
------------

// File: rtl/pic_host_ctrl_pkg.sv
// Shared types and constants for the 8259A host-side controller.
package pic_host_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WSETUP,
    ST_WPULSE,
    ST_WHOLD,
    ST_READY,
    ST_ACK1,
    ST_AGAP,
    ST_ACK2,
    ST_VEC,
    ST_RECOVER
  } state_t;

  localparam logic A0_ICW1  = 1'b0;
  localparam logic A0_OTHER = 1'b1;

  localparam int IC4  = 0;
  localparam int SNGL = 1;

  localparam logic [2:0] STEP_ICW1 = 3'd0;
  localparam logic [2:0] STEP_ICW2 = 3'd1;
  localparam logic [2:0] STEP_ICW3 = 3'd2;
  localparam logic [2:0] STEP_ICW4 = 3'd3;
  localparam logic [2:0] STEP_OCW1 = 3'd4;

endpackage

// File: rtl/pic_host_ctrl_bus_timer.sv
// Loadable 8-bit down-counter; times every bus phase of the host controller.
module pic_bus_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/pic_host_ctrl.sv
// Host-side bus master for an 8259A: ICW init, single OCW writes, INTA cycles.
module pic_host_ctrl
  import pic_host_pkg::*;
#(
  parameter logic [7:0] ICW1      = 8'h13,
  parameter logic [7:0] ICW2      = 8'hA8,
  parameter logic [7:0] ICW3      = 8'h00,
  parameter logic [7:0] ICW4      = 8'h01,
  parameter logic [7:0] OCW1      = 8'h00,
  parameter int         SETUP_CYC = 2,
  parameter int         PULSE_CYC = 3,
  parameter int         HOLD_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       init_done,
  output logic       busy,
  input  logic       ocw_req,
  input  logic       ocw_a0,
  input  logic [7:0] ocw_data,
  output logic       ocw_ack,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  input  logic       intr,
  output logic       inta_n,
  output logic       vec_valid,
  output logic [7:0] vec_data
);

  localparam logic [7:0] LD_SETUP = 8'(SETUP_CYC - 1);
  localparam logic [7:0] LD_PULSE = 8'(PULSE_CYC - 1);
  localparam logic [7:0] LD_HOLD  = 8'(HOLD_CYC - 1);

  state_t     state;
  logic [2:0] step;
  logic       is_ocw;
  logic [1:0] intr_sync;
  logic       irq;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic [7:0] tmr_count;
  logic       tmr_zero;
  logic       ack_next;

  // Skip ICW3 in single mode and ICW4 when IC4 is clear.
  function automatic logic [2:0] next_step(input logic [2:0] s);
    logic [2:0] n;
    n = s + 3'd1;
    if (n == STEP_ICW3 && ICW1[SNGL]) n = STEP_ICW4;
    if (n == STEP_ICW4 && !ICW1[IC4]) n = STEP_OCW1;
    return n;
  endfunction

  function automatic logic [7:0] word_at(input logic [2:0] s);
    case (s)
      STEP_ICW1: return ICW1;
      STEP_ICW2: return ICW2;
      STEP_ICW3: return ICW3;
      STEP_ICW4: return ICW4;
      default:   return OCW1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) intr_sync <= 2'b00;
    else        intr_sync <= {intr_sync[0], intr};
  end

  assign irq  = intr_sync[1];
  assign rd_n = 1'b1;

  pic_bus_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // The timer is reloaded on the same edge that enters each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state)
      ST_IDLE:    if (start)    begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_WSETUP:  if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_PULSE; end
      ST_WPULSE:  if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_WHOLD:   if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_READY: begin
        if (irq)          begin tmr_load = 1'b1; tmr_val = LD_PULSE; end
        else if (ocw_req) begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      end
      ST_ACK1:    if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_AGAP:    if (tmr_zero) begin tmr_load = 1'b1; tmr_val = LD_PULSE; end
      ST_VEC:     begin tmr_load = 1'b1; tmr_val = LD_HOLD; end
      default:    ;
    endcase
  end

  // ocw_ack is registered, so it is raised one edge before the last hold cycle.
  assign ack_next = is_ocw &&
                    ((HOLD_CYC == 1) ? (state == ST_WPULSE && tmr_zero)
                                     : (state == ST_WHOLD && tmr_count == 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step      <= STEP_ICW1;
      is_ocw    <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      ocw_ack   <= 1'b0;
      cs_n      <= 1'b1;
      wr_n      <= 1'b1;
      a0        <= 1'b0;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      inta_n    <= 1'b1;
      vec_valid <= 1'b0;
      vec_data  <= 8'h00;
    end else begin
      ocw_ack   <= ack_next;
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_WSETUP;
            busy   <= 1'b1;
            step   <= STEP_ICW1;
            is_ocw <= 1'b0;
            cs_n   <= 1'b0;
            d_oe   <= 1'b1;
            a0     <= A0_ICW1;
            d_out  <= ICW1;
          end
        end
        ST_WSETUP: begin
          if (tmr_zero) begin
            state <= ST_WPULSE;
            wr_n  <= 1'b0;
          end
        end
        ST_WPULSE: begin
          if (tmr_zero) begin
            state <= ST_WHOLD;
            wr_n  <= 1'b1;
          end
        end
        ST_WHOLD: begin
          if (tmr_zero) begin
            if (!is_ocw && step != STEP_OCW1) begin
              // Init words run back to back with CS held low.
              state <= ST_WSETUP;
              step  <= next_step(step);
              a0    <= A0_OTHER;
              d_out <= word_at(next_step(step));
            end else begin
              state     <= ST_READY;
              busy      <= 1'b0;
              cs_n      <= 1'b1;
              d_oe      <= 1'b0;
              is_ocw    <= 1'b0;
              init_done <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (irq) begin
            state  <= ST_ACK1;
            busy   <= 1'b1;
            inta_n <= 1'b0;
          end else if (ocw_req) begin
            state  <= ST_WSETUP;
            busy   <= 1'b1;
            is_ocw <= 1'b1;
            cs_n   <= 1'b0;
            d_oe   <= 1'b1;
            a0     <= ocw_a0;
            d_out  <= ocw_data;
          end
        end
        ST_ACK1: begin
          if (tmr_zero) begin
            state  <= ST_AGAP;
            inta_n <= 1'b1;
          end
        end
        ST_AGAP: begin
          if (tmr_zero) begin
            state  <= ST_ACK2;
            inta_n <= 1'b0;
          end
        end
        ST_ACK2: begin
          if (tmr_zero) begin
            state     <= ST_VEC;
            inta_n    <= 1'b1;
            vec_valid <= 1'b1;
            vec_data  <= d_in;
          end
        end
        ST_VEC: begin
          state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (tmr_zero) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_host_ctrl.sv
// Self-checking bench for pic_host_ctrl with a small 8259A-side model.
module tb_pic_host_ctrl;

  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int HOLD  = 2;
  localparam int WLEN  = SETUP + PULSE + HOLD;

  typedef struct {
    logic       a0;
    logic [7:0] data;
  } wvec_t;

  typedef struct {
    logic       a0;
    logic [7:0] data;
    int         start;
    int         low;
    bit         ok;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       init_done, busy, ocw_ack, cs_n, wr_n, rd_n, a0, d_oe, inta_n, vec_valid;
  logic       ocw_req = 1'b0;
  logic       ocw_a0 = 1'b0;
  logic [7:0] ocw_data = 8'h00;
  logic [7:0] d_out, d_in, vec_data;
  logic       intr = 1'b0;

  logic       start2 = 1'b0;
  logic       init_done2, busy2, ocw_ack2, cs_n2, wr_n2, rd_n2, a0_2, d_oe2, inta_n2, vec_valid2;
  logic [7:0] d_out2, vec_data2;

  logic [7:0] cur_vec = 8'h00;
  int         pulses = 0;

  int n_chk = 0;
  int n_pass = 0;

  pulse_t wq[$];
  wvec_t  wq2[$];
  pulse_t cur;
  bit     in_p = 1'b0;
  bit     cs_prev = 1'b1;
  int     cyc = 0, cs_fall = 0, cs_rise = 0, ack_cyc = 0, n_ack = 0, done_cyc = 0, oe_bad = 0;

  always #5 clk = ~clk;

  pic_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_done(init_done), .busy(busy),
    .ocw_req(ocw_req), .ocw_a0(ocw_a0), .ocw_data(ocw_data), .ocw_ack(ocw_ack),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .d_out(d_out), .d_oe(d_oe),
    .d_in(d_in), .intr(intr), .inta_n(inta_n), .vec_valid(vec_valid), .vec_data(vec_data)
  );

  pic_host_ctrl #(.ICW1(8'h10)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .init_done(init_done2), .busy(busy2),
    .ocw_req(1'b0), .ocw_a0(1'b0), .ocw_data(8'h00), .ocw_ack(ocw_ack2),
    .cs_n(cs_n2), .wr_n(wr_n2), .rd_n(rd_n2), .a0(a0_2), .d_out(d_out2), .d_oe(d_oe2),
    .d_in(8'h00), .intr(1'b0), .inta_n(inta_n2), .vec_valid(vec_valid2), .vec_data(vec_data2)
  );

  // PIC side: the vector byte is only on D during the second INTA pulse.
  always @(negedge inta_n) pulses++;
  assign d_in = (!inta_n && pulses == 2) ? cur_vec : 8'h5A;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!wr_n) begin
      if (!in_p) begin
        in_p = 1'b1;
        cur.a0 = a0; cur.data = d_out; cur.start = cyc; cur.low = 0; cur.ok = 1'b1;
      end
      cur.low++;
      if (cs_n || !d_oe || a0 !== cur.a0 || d_out !== cur.data) cur.ok = 1'b0;
    end else if (in_p) begin
      in_p = 1'b0;
      wq.push_back(cur);
    end
    if (!cs_n && !d_oe) oe_bad++;
    if (!cs_n && cs_prev) cs_fall = cyc;
    if (cs_n && !cs_prev) cs_rise = cyc;
    cs_prev = cs_n;
    if (ocw_ack) begin ack_cyc = cyc; n_ack++; end
    if (init_done && done_cyc == 0) done_cyc = cyc;
    if (!inta_n) begin
      check("inta_vs_wr", wr_n, 1);
      check("inta_vs_oe", d_oe, 0);
    end
  end

  always @(posedge wr_n2) if (rst_n) wq2.push_back('{a0_2, d_out2});

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_ocw(input logic a, input logic [7:0] d);
    int n0, na;
    bit got;
    pulse_t p;
    n0 = wq.size(); na = n_ack; got = 1'b0;
    ocw_a0 = a; ocw_data = d; ocw_req = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (ocw_ack) got = 1'b1;
    end
    ocw_req = 1'b0;
    check("ocw_ack_seen", got, 1);
    tick();
    check("busy_after_ocw", busy, 0);
    check("cs_n_after_ocw", cs_n, 1);
    check("ocw_ack_count", n_ack - na, 1);
    check("ocw_pulse_count", wq.size() - n0, 1);
    if (wq.size() > n0) begin
      p = wq[wq.size()-1];
      check("ocw_a0", p.a0, a);
      check("ocw_data", p.data, d);
      check("ocw_low", p.low, PULSE);
      check("ocw_stable", p.ok, 1);
      check("ocw_setup", p.start - cs_fall, SETUP);
    end
    check("ocw_ack_pos", ack_cyc - cs_fall, WLEN - 1);
    check("ocw_len", cs_rise - cs_fall, WLEN);
  endtask

  task automatic do_int(input logic [7:0] vec);
    bit ib[$];
    bit vb[$];
    bit got;
    int oe, f, bad, nv;
    cur_vec = vec; pulses = 0; intr = 1'b1; got = 1'b0; oe = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      ib.push_back(inta_n); vb.push_back(vec_valid);
      if (!inta_n) intr = 1'b0;
      if (d_oe) oe++;
      if (vec_valid) got = 1'b1;
    end
    intr = 1'b0;
    check("vec_seen", got, 1);
    repeat (HOLD + 1) begin
      tick();
      ib.push_back(inta_n); vb.push_back(vec_valid);
      if (d_oe) oe++;
    end
    check("busy_after_int", busy, 0);
    check("vec_data", vec_data, vec);
    check("d_oe_during_inta", oe, 0);
    check("inta_pulses", pulses, 2);
    f = -1;
    foreach (ib[k]) if (f < 0 && !ib[k]) f = k;
    nv = 0;
    foreach (vb[k]) if (vb[k]) nv++;
    check("vec_valid_count", nv, 1);
    if (f < 0 || f + 2*PULSE + HOLD >= ib.size()) begin
      bad = 99;
    end else begin
      bad = 0;
      for (int k = 0; k <= 2*PULSE + HOLD; k++)
        if (ib[f+k] != !(k < PULSE || (k >= PULSE + HOLD && k < 2*PULSE + HOLD))) bad++;
      if (!vb[f + 2*PULSE + HOLD]) bad++;
    end
    check("inta_shape", bad, 0);
  endtask

  wvec_t      init_tab[4];
  wvec_t      init2_tab[4];
  wvec_t      ocw_tab[4];
  logic [7:0] last_vec;
  int         n0, vcyc, acyc;
  bit         reached;

  initial begin
    init_tab[0]  = '{1'b0, 8'h13}; init_tab[1]  = '{1'b1, 8'hA8};
    init_tab[2]  = '{1'b1, 8'h01}; init_tab[3]  = '{1'b1, 8'h00};
    init2_tab[0] = '{1'b0, 8'h10}; init2_tab[1] = '{1'b1, 8'hA8};
    init2_tab[2] = '{1'b1, 8'h00}; init2_tab[3] = '{1'b1, 8'h00};
    ocw_tab[0]   = '{1'b1, 8'hFE}; ocw_tab[1]   = '{1'b0, 8'h0B};
    ocw_tab[2]   = '{1'b1, 8'h00}; ocw_tab[3]   = '{1'b0, 8'h20};

    repeat (3) tick();
    check("rst_cs_n", cs_n, 1);        check("rst_wr_n", wr_n, 1);
    check("rst_rd_n", rd_n, 1);        check("rst_inta_n", inta_n, 1);
    check("rst_a0", a0, 0);            check("rst_d_out", d_out, 0);
    check("rst_d_oe", d_oe, 0);        check("rst_init_done", init_done, 0);
    check("rst_busy", busy, 0);        check("rst_ocw_ack", ocw_ack, 0);
    check("rst_vec_valid", vec_valid, 0); check("rst_vec_data", vec_data, 0);
    rst_n = 1'b1;
    tick();

    ocw_req = 1'b1; intr = 1'b1;
    repeat (4) tick();
    check("no_ack_before_init", n_ack, 0);
    check("no_inta_before_init", inta_n, 1);
    ocw_req = 1'b0; intr = 1'b0;
    tick();

    start = 1'b1; start2 = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 200 && !(init_done && init_done2); i++) tick();
    check("init_done", init_done, 1);
    check("init_done2", init_done2, 1);
    check("busy_after_init", busy, 0);
    check("init_count", wq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wq.size()) begin
        check("init_a0", wq[k].a0, init_tab[k].a0);
        check("init_data", wq[k].data, init_tab[k].data);
        check("init_low", wq[k].low, PULSE);
        check("init_stable", wq[k].ok, 1);
        check("init_pulse_at", wq[k].start - cs_fall, k*WLEN + SETUP);
      end
    end
    check("init_done_at", done_cyc - cs_fall, 4*WLEN);
    check("init_cs_rise_at", cs_rise - cs_fall, 4*WLEN);
    check("init_no_ack", n_ack, 0);
    check("init2_count", wq2.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < wq2.size()) begin
        check("init2_a0", wq2[k].a0, init2_tab[k].a0);
        check("init2_data", wq2[k].data, init2_tab[k].data);
      end
    end
    check("dut2_idle", {busy2, cs_n2, rd_n2, inta_n2, d_oe2, ocw_ack2, vec_valid2, vec_data2},
          {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    foreach (ocw_tab[k]) do_ocw(ocw_tab[k].a0, ocw_tab[k].data);

    do_int(8'hA8);
    last_vec = 8'hA8;

    cur_vec = 8'h47; pulses = 0; intr = 1'b1;
    tick(); tick();
    ocw_a0 = 1'b1; ocw_data = 8'h3C; ocw_req = 1'b1;
    n0 = wq.size(); vcyc = 0; acyc = 0;
    for (int i = 0; i < 80 && acyc == 0; i++) begin
      tick();
      if (!inta_n) intr = 1'b0;
      if (vec_valid) vcyc = cyc;
      if (ocw_ack) acyc = cyc;
    end
    ocw_req = 1'b0; intr = 1'b0;
    tick();
    check("both_vec_seen", vcyc != 0, 1);
    check("both_ack_after_vec", acyc > vcyc && vcyc != 0, 1);
    check("both_vec_data", vec_data, 8'h47);
    check("both_write_count", wq.size() - n0, 1);
    if (wq.size() > n0) check("both_write_data", wq[wq.size()-1].data, 8'h3C);
    last_vec = 8'h47;

    for (int r = 0; r < 16; r++) begin
      logic [7:0] v;
      repeat ($urandom_range(0, 3)) tick();
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        do_int(v);
        last_vec = v;
      end else begin
        do_ocw(1'($urandom_range(0, 1)), v);
        check("vec_hold", vec_data, last_vec);
      end
    end
    check("d_oe_with_cs", oe_bad, 0);

    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    wq.delete();
    start = 1'b1; tick(); start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      reached = (wq.size() == 1 && !wr_n && !cs_n);
    end
    check("reached_icw2_pulse", reached, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_wr_n", wr_n, 1);
    check("abort_d_oe", d_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_init_done", init_done, 0);
    tick(); rst_n = 1'b1; tick();
    wq.delete();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40 && wq.size() == 0; i++) tick();
    check("restart_count", wq.size() >= 1, 1);
    if (wq.size() >= 1) begin
      check("restart_a0", wq[0].a0, 0);
      check("restart_data", wq[0].data, 8'h13);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
